axi_prefetch_scheduler: RTL

//  Shares the single AXI_prefetch1k master engine between NUM_REQ requesters.

---
 rtl/axi_prefetch_scheduler_pkg.sv | 29 ++
 rtl/axi_prefetch_scheduler_if.sv | 29 ++
 rtl/axi_prefetch_scheduler_rr_arbiter.sv | 37 +++
 rtl/axi_prefetch_scheduler.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/axi_prefetch_scheduler_pkg.sv
// Shared types and helpers for the prefetch-engine scheduler.
//   state_t        : scheduler FSM states (2-bit)
//   cmpl_status_t  : completion qualifiers returned with cmpl_valid
//   ERR_CNT_W      : width of the saturating error counter
//   clog2()        : ceil(log2(value)), 0 for value <= 1
package axi_prefetch_sched_pkg;

  localparam int unsigned ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    CMPL   = 2'd3
  } state_t;

  typedef struct packed {
    logic error;
    logic timeout;
  } cmpl_status_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/axi_prefetch_scheduler_if.sv
// Requester-side command/completion bundle of the prefetch scheduler.
//   req_valid/req_addr/req_len : packed per-requester commands (requester i at slice i)
//   req_ready                  : one-hot accept
//   cmpl_valid                 : one-hot completion pulse to the owning requester
//   cmpl_error/cmpl_timeout    : qualifiers of cmpl_valid
// master = command sources, slave = scheduler.
interface axi_prefetch_scheduler_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 11
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            cmpl_valid;
  logic                          cmpl_error;
  logic                          cmpl_timeout;

  modport master (
    output req_valid, req_addr, req_len,
    input  req_ready, cmpl_valid, cmpl_error, cmpl_timeout
  );

  modport slave (
    input  req_valid, req_addr, req_len,
    output req_ready, cmpl_valid, cmpl_error, cmpl_timeout
  );
endinterface

// File: rtl/axi_prefetch_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : last served requester; search starts at (ptr+1) mod NUM_REQ
//   grant : one-hot grant (zero when no request)
//   id    : encoded grant index
module rr_arbiter
  import axi_prefetch_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id
);

  logic [ID_W-1:0] idx;
  logic            found;

  // First requester at or after ptr+1, wrapping around.
  always_comb begin
    grant = '0;
    id    = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = idx;
      end
    end
  end

endmodule

// File: rtl/axi_prefetch_scheduler.sv
// Shares one prefetch engine between NUM_REQ requesters: round-robin picks a
// command, latches it, pulses INIT, waits for TXN_DONE under a watchdog and
// returns a one-hot completion with error/timeout status.
//   ACLK, ARESETN          : clock, async active-low reset
//   req_if (slave)         : requester commands and completions
//   eng_base_addr, eng_len : latched command to the engine
//   M00_AXI_INIT_AXI_TXN   : 1-cycle engine start pulse
//   M00_AXI_TXN_DONE/ERROR : engine completion level and error
//   busy                   : scheduler not in IDLE
//   err_count              : saturating count of error completions
module axi_prefetch_scheduler
  import axi_prefetch_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned LEN_WIDTH      = 11,
  parameter int unsigned DONE_BLANK     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  axi_prefetch_scheduler_if.slave req_if,
  output logic [ADDR_WIDTH-1:0] eng_base_addr,
  output logic [LEN_WIDTH-1:0]  eng_len,
  output logic                  M00_AXI_INIT_AXI_TXN,
  input  logic                  M00_AXI_TXN_DONE,
  input  logic                  M00_AXI_ERROR,
  output logic                  busy,
  output logic [ERR_CNT_W-1:0]  err_count
);

  localparam int unsigned ID_W   = clog2(NUM_REQ);
  localparam int unsigned WDOG_W = clog2(TIMEOUT_CYCLES);

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     grant_id;
  logic [WDOG_W-1:0]   wdog;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]     arb_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LEN_WIDTH-1:0]  sel_len;
  logic [NUM_REQ-1:0]  cmpl_valid_q;
  logic                cmpl_error_q;
  logic                cmpl_timeout_q;
  logic                done_seen;
  logic                timeout_hit;
  cmpl_status_t        wait_status;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req   (req_if.req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .id    (arb_id)
  );

  assign req_if.req_ready    = (state == IDLE) ? arb_grant : '0;
  assign req_if.cmpl_valid   = cmpl_valid_q;
  assign req_if.cmpl_error   = cmpl_error_q;
  assign req_if.cmpl_timeout = cmpl_timeout_q;

  // Command slice of the current grantee.
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_id == ID_W'(i)) begin
        sel_addr = req_if.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = req_if.req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // wdog holds the number of cycles since INIT rose; a DONE still high from
  // the previous transfer is ignored during the first DONE_BLANK cycles.
  assign done_seen   = M00_AXI_TXN_DONE && (wdog >= WDOG_W'(DONE_BLANK));
  assign timeout_hit = (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

  // DONE wins over a coincident timeout.
  always_comb begin
    wait_status = '{error: 1'b1, timeout: 1'b1};
    if (done_seen) wait_status = '{error: M00_AXI_ERROR, timeout: 1'b0};
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state                <= IDLE;
      rr_ptr               <= ID_W'(NUM_REQ - 1);
      grant_id             <= '0;
      wdog                 <= '0;
      eng_base_addr        <= '0;
      eng_len              <= '0;
      M00_AXI_INIT_AXI_TXN <= 1'b0;
      cmpl_valid_q         <= '0;
      cmpl_error_q         <= 1'b0;
      cmpl_timeout_q       <= 1'b0;
      busy                 <= 1'b0;
      err_count            <= '0;
    end else begin
      M00_AXI_INIT_AXI_TXN <= 1'b0;
      cmpl_valid_q         <= '0;
      cmpl_error_q         <= 1'b0;
      cmpl_timeout_q       <= 1'b0;
      case (state)
        IDLE: begin
          if (|arb_grant) begin
            eng_base_addr <= sel_addr;
            eng_len       <= sel_len;
            grant_id      <= arb_id;
            wdog          <= '0;
            busy          <= 1'b1;
            if (sel_len != '0) begin
              state                <= LAUNCH;
              M00_AXI_INIT_AXI_TXN <= 1'b1;
            end else begin
              // Zero-length command completes without touching the engine.
              state        <= CMPL;
              cmpl_valid_q <= arb_grant;
            end
          end
        end
        LAUNCH: begin
          wdog  <= wdog + WDOG_W'(1);
          state <= WAIT;
        end
        WAIT: begin
          if (done_seen || timeout_hit) begin
            state          <= CMPL;
            cmpl_valid_q   <= NUM_REQ'(1) << grant_id;
            cmpl_error_q   <= wait_status.error;
            cmpl_timeout_q <= wait_status.timeout;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end
        CMPL: begin
          rr_ptr <= grant_id;
          if (cmpl_error_q && (err_count != '1)) err_count <= err_count + ERR_CNT_W'(1);
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
